// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: pipeline <-> multiply/divide unit signal bundle.
//   master modport: Execute-stage pipeline (drives start/op/operands,
//                   observes stall, done strobe and result).
//   slave modport : muldiv_unit.
// Signals: MulStartE, MulOpE[2:0], SrcAE, SrcBE (pipeline -> unit);
//          MulBusy, MulDoneE, MulResultE (unit -> pipeline).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             MulStartE;
  logic [2:0]       MulOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             MulBusy;
  logic             MulDoneE;
  logic [WIDTH-1:0] MulResultE;

  modport master (
    output MulStartE, MulOpE, SrcAE, SrcBE,
    input  MulBusy, MulDoneE, MulResultE
  );

  modport slave (
    input  MulStartE, MulOpE, SrcAE, SrcBE,
    output MulBusy, MulDoneE, MulResultE
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit in the Execute stage.
//   Multiply: shift-add, one multiplier bit per cycle (LSB first).
//   Divide  : restoring division, one quotient bit per cycle (MSB first).
//   Operands are reduced to magnitudes at start; the result sign is fixed
//   up combinationally while the result is presented.
// Ports:
//   clk   - pipeline clock
//   reset - synchronous, active-high reset
//   bus   - muldiv_unit_if.slave (MulStartE, MulOpE, SrcAE, SrcBE in;
//           MulBusy, MulDoneE, MulResultE out)
// Configuration:
//   MULDIV_DIV_EN - when defined, DIV/DIVU/REM/REMU are computed. When
//   undefined the divider is not built: funct3[2]=1 ops go straight to
//   DONE with a zero result after a single stall cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand (shifted left each step) for multiply; for divide the
  // low word is the dividend, shifted left so its MSB feeds the remainder.
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  // Multiplier (shifted right each step) or divisor (held).
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // ---------------- start-cycle operand conditioning ----------------
  logic             in_is_div;
  logic             in_a_signed, in_b_signed;
  logic             in_div_zero;
  logic             in_sa, in_sb;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic             in_neg;

  assign in_is_div   = bus.MulOpE[2];
  // MULH (001), MULHSU (010), DIV (100), REM (110) treat rs1 as signed.
  assign in_a_signed = (bus.MulOpE == 3'b001) || (bus.MulOpE == 3'b010) ||
                       (bus.MulOpE == 3'b100) || (bus.MulOpE == 3'b110);
  // MULH, DIV, REM treat rs2 as signed.
  assign in_b_signed = (bus.MulOpE == 3'b001) || (bus.MulOpE == 3'b100) ||
                       (bus.MulOpE == 3'b110);
  assign in_div_zero = in_is_div && (bus.SrcBE == '0);
  // On divide-by-zero the operands are used raw and unsigned: the
  // restoring loop then yields all-ones quotient and remainder = rs1.
  assign in_sa       = in_a_signed && bus.SrcAE[WIDTH-1] && !in_div_zero;
  assign in_sb       = in_b_signed && bus.SrcBE[WIDTH-1] && !in_div_zero;
  assign in_mag_a    = in_sa ? (-bus.SrcAE) : bus.SrcAE;
  assign in_mag_b    = in_sb ? (-bus.SrcBE) : bus.SrcBE;
  // Remainder takes the dividend's sign; product and quotient the XOR.
  assign in_neg      = (in_is_div && bus.MulOpE[1]) ? in_sa : (in_sa ^ in_sb);

`ifdef MULDIV_DIV_EN
  // One restoring-division step: shift next dividend bit into the
  // partial remainder and try subtracting the divisor.
  logic [WIDTH:0] rem_sh, rem_diff;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], mcand_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
`endif

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.MulStartE) begin
          op_d    = bus.MulOpE;
          neg_d   = in_neg;
          acc_d   = '0;
          cnt_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, in_mag_a};
          opb_d   = in_mag_b;
          state_d = S_BUSY;
`ifndef MULDIV_DIV_EN
          if (bus.MulOpE[2]) begin
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        if (!op_q[2]) begin
          acc_d   = acc_q + (opb_q[0] ? mcand_q : '0);
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
        end
`ifdef MULDIV_DIV_EN
        else begin
          mcand_d = mcand_q << 1;
          acc_d   = {rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0],
                     acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        end
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // MulStartE still belongs to the completing instruction here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- result fix-up and outputs ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   result;

  assign prod_fix = neg_q ? (-acc_q) : acc_q;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign quot_fix = neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    result = '0;
    if (state_q == S_DONE) begin
      if (!op_q[2]) begin
        result = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                      : prod_fix[2*WIDTH-1:WIDTH];
      end
`ifdef MULDIV_DIV_EN
      else begin
        result = op_q[1] ? rem_fix : quot_fix;
      end
`endif
    end
  end

  assign bus.MulBusy    = !reset && (((state_q == S_IDLE) && bus.MulStartE) ||
                                     (state_q == S_BUSY));
  assign bus.MulDoneE   = (state_q == S_DONE);
  assign bus.MulResultE = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed test-plan
// cases plus random operations checked against a plain-arithmetic model.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sp;
    logic [63:0] up;
    int         sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (op[2] && !DIV_EN) return 32'h0;
    case (op)
      3'b000: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'b001: begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
      3'b010: begin sp = longint'(sa) * longint'({32'h0, b}); up = sp; return up[63:32]; end
      3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return -$urandom_range(1, 20);
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  // Issue one op (start held high through DONE, as a stalled pipeline
  // would) and check stall length, done timing, result and idle outputs.
  // Returns just after the negedge following DONE, start still asserted.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] exp_res;
    int          exp_lat;
    int          cyc;
    int          busy_cnt;
    int          done_cyc;
    logic [31:0] res;
    bit          zero_ok;
    exp_res  = ref_model(op, a, b);
    exp_lat  = (op[2] && !DIV_EN) ? 1 : 33;
    bus.MulStartE = 1'b1;
    bus.MulOpE    = op;
    bus.SrcAE     = a;
    bus.SrcBE     = b;
    cyc      = 0;
    busy_cnt = 0;
    done_cyc = -1;
    res      = 32'h0;
    zero_ok  = 1'b1;
    while (done_cyc < 0 && cyc < 100) begin
      #1;
      if (bus.MulBusy) busy_cnt++;
      if (bus.MulDoneE) begin
        done_cyc = cyc;
        res      = bus.MulResultE;
      end else if (bus.MulResultE !== 32'h0) begin
        zero_ok = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.SrcAE = $urandom;
        bus.SrcBE = $urandom;
      end
    end
    #1;
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_lat));
    check({tag, " result"}, {32'h0, res}, {32'h0, exp_res});
    check({tag, " result_zero_outside_done"}, {63'h0, zero_ok}, 64'h1);
    check({tag, " done_one_cycle"}, {63'h0, bus.MulDoneE}, 64'h0);
    $display("op %s funct3=%0d a=%h b=%h result=%h expected=%h busy=%0d",
             tag, op, a, b, res, exp_res, busy_cnt);
  endtask

  initial begin
    int   dcnt;
    int   bcnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.MulStartE = 1'b0;
    bus.MulOpE    = 3'b000;
    bus.SrcAE     = 32'h0;
    bus.SrcBE     = 32'h0;
    repeat (3) @(negedge clk);
    bus.MulStartE = 1'b1;
    #1;
    check("reset busy_forced_low", {63'h0, bus.MulBusy}, 64'h0);
    check("reset done", {63'h0, bus.MulDoneE}, 64'h0);
    check("reset result", {32'h0, bus.MulResultE}, 64'h0);
    bus.MulStartE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed test-plan cases, issued back to back.
    run_op(3'b000, 32'd7,        32'hFFFF_FFFD, "MUL_7xm3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU_max");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH_m1xm1");
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2,         "MULHSU_m1x2");
    run_op(3'b100, 32'd20,        32'd0,         "DIV_by0");
    run_op(3'b111, 32'd20,        32'd0,         "REMU_by0");
    run_op(3'b100, -32'sd7,       32'd2,         "DIV_m7_2");
    run_op(3'b110, -32'sd7,       32'd2,         "REM_m7_2");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "DIV_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "REM_ovf");
    run_op(3'b101, 32'd10,        32'd3,         "DIVU_10_3");

    // Reset in the middle of a multiply.
    bus.MulOpE    = 3'b000;
    bus.SrcAE     = 32'd5;
    bus.SrcBE     = 32'd6;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy_low", {63'h0, bus.MulBusy}, 64'h0);
    @(negedge clk);
    #1;
    check("midreset busy_low_held", {63'h0, bus.MulBusy}, 64'h0);
    check("midreset no_done", {63'h0, bus.MulDoneE}, 64'h0);
    bus.MulStartE = 1'b0;
    reset = 1'b0;
    dcnt = 0;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.MulDoneE) dcnt++;
      if (bus.MulBusy) bcnt++;
    end
    check("midreset done_never", 64'(dcnt), 64'h0);
    check("midreset idle_after", 64'(bcnt), 64'h0);
    @(negedge clk);
    run_op(3'b000, 32'd3, 32'd4, "MUL_3x4_after_reset");

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, "random");
    end
    bus.MulStartE = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the Execute stage. It is the producer side of the `MulBusy` stall signal consumed by the hazard unit. When an M-extension instruction reaches EX, the unit raises `MulBusy` in that same cycle, which freezes Fetch, Decode and the ID/EX register. It computes for a fixed number of cycles, then drops `MulBusy` and presents the result for exactly one cycle so the instruction can advance to MEM.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width. Only 32 is supported for RV32M.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high reset.
- `MulStartE`  in  1  valid M-extension instruction in EX (from the ID/EX register).
- `MulOpE`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE`  in  WIDTH  rs1 operand, after forwarding.
- `SrcBE`  in  WIDTH  rs2 operand, after forwarding.
- `MulBusy`  out  1  stall request to the hazard unit; the top level also uses it to hold ID/EX.
- `MulDoneE`  out  1  one-cycle result-valid strobe.
- `MulResultE`  out  WIDTH  result; muxed into ALUResultE when `MulDoneE` is high.

## Operation
- Clock is `clk`. Reset is `reset`, synchronous and active-high.
- States:
  - IDLE: no operation in progress.
  - BUSY: iteration counter runs 0..WIDTH-1.
  - DONE: result is presented.
- IDLE with `MulStartE` = 1 (start cycle):
  - Latch `MulOpE`.
  - Latch operand magnitudes. Signed operands are taken by two's-complement absolute value: MULH takes both signed, MULHSU takes only rs1 signed, DIV/REM take both signed.
  - Latch the result-sign flag:
    - multiply: signA XOR signB.
    - quotient: signA XOR signB.
    - remainder: signA.
  - Clear the 2·WIDTH accumulator. Go to BUSY with counter = 0.
- BUSY, multiply: shift-add, one multiplier bit per cycle, LSB first.
- BUSY, divide: restoring division, one quotient bit per cycle, MSB first.
- BUSY exit: after counter = WIDTH-1, go to DONE.
- DONE:
  - Apply sign fix-up combinationally: negate the 64-bit product, quotient or remainder when the sign flag is set.
  - Select the output: MUL takes the low word; MULH/MULHSU/MULHU take the high word.
  - Go to IDLE next cycle unconditionally. `MulStartE` is ignored in DONE because it still refers to the completing instruction.
- Divide by zero (rs2 = 0): quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = rs1 unmodified. Detected at start; sign fix-up is suppressed.
- Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out of the magnitude algorithm plus fix-up and must be verified.
- Outputs:
  - `MulBusy` = (IDLE & `MulStartE`) | BUSY. It is forced to 0 while `reset` is high.
  - `MulDoneE` = DONE.
  - `MulResultE` = 0 outside DONE.
- Reset mid-operation: next state is IDLE. Accumulator and counter are cleared. No `MulDoneE` is produced. The partial result is discarded.
- Reset values: state IDLE, `MulBusy` 0, `MulDoneE` 0, `MulResultE` 0.

## Timing
- Cycle 0 (start): `MulBusy` = 1, combinational from `MulStartE`.
- Cycles 1..WIDTH: BUSY, `MulBusy` = 1.
- Cycle WIDTH+1: DONE. `MulBusy` = 0, `MulDoneE` = 1, `MulResultE` valid. The instruction moves to MEM at the end of this cycle.
- Total stall: WIDTH+1 = 33 cycles. End-to-end latency: 34 cycles.
- Back-to-back M instructions: a second op in EX the cycle after DONE starts immediately from IDLE. There is no idle gap beyond the DONE cycle.
- Operands are sampled only in the start cycle. Later changes on `SrcAE`/`SrcBE` have no effect.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Full RV32M; divide/remainder follow the iterative path above.
- `MULDIV_DIV_EN` undefined:
  - Divider datapath is not compiled.
  - funct3[2] = 1 ops go IDLE → DONE directly: `MulBusy` high for 1 cycle, `MulResultE` = 0.
  - Multiply behaviour is unchanged.

## Test plan
- MUL 7 × 0xFFFFFFFD -> `MulBusy` high for cycles 0–32; `MulDoneE` high at cycle 33 only; `MulResultE` = 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0x00000014 / 0 -> 0xFFFFFFFF. REMU 0x00000014 / 0 -> 0x00000014. DIV −7 / 2 -> 0xFFFFFFFD. REM −7 / 2 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0x00000000.
- MUL started, `reset` pulsed at cycle 10 -> `MulBusy` = 0 while reset is high, state IDLE, no `MulDoneE` ever. A fresh MUL 3 × 4 afterwards -> 0x0000000C after 34 cycles.
- With `MULDIV_DIV_EN` undefined: DIVU 10 / 3 -> `MulBusy` high 1 cycle, `MulDoneE` at cycle 1, result 0. MUL is unaffected.
